// File: rtl/root_arbiter_if.sv
// Requester and root-unit signal bundle for root_arbiter; slave is the arbiter's view,
// master is the view of whoever plays the requesters and the root unit.
interface root_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_i;
  logic [16*N_REQ-1:0] x_bi;
  logic [N_REQ-1:0]    ack_o;
  logic [N_REQ-1:0]    done_o;
  logic [8*N_REQ-1:0]  y_bo;
  logic [N_REQ-1:0]    err_o;
  logic                busy_o;
  logic                root_start_o;
  logic [15:0]         root_x_bo;
  logic [7:0]          root_y_bi;
  logic [1:0]          root_busy_bi;

  modport slave (
    input  req_i, x_bi, root_y_bi, root_busy_bi,
    output ack_o, done_o, y_bo, err_o, busy_o, root_start_o, root_x_bo
  );

  modport master (
    output req_i, x_bi, root_y_bi, root_busy_bi,
    input  ack_o, done_o, y_bo, err_o, busy_o, root_start_o, root_x_bo
  );
endinterface

// File: rtl/root_arbiter.sv
// Round-robin sequencer sharing one sqrt unit: grant->ack in 1 cycle, done 1 cycle after busy drops.
// Requesters hold req until ack; a stalled root unit is aborted by the watchdog.
module root_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  root_arbiter_if.slave bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [GW-1:0]      gnt_q, gnt_d;
  logic [7:0]         wdog_q, wdog_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic [7:0]         y_q [N_REQ];
  logic [7:0]         y_d [N_REQ];
  logic               start_q, start_d;
  logic [15:0]        rx_q, rx_d;

  logic [15:0]        x_arr [N_REQ];
  logic               pick_vld;
  logic [GW-1:0]      pick;
  logic [GW-1:0]      ptr_inc;
  logic               root_idle;
  logic               wdog_hit;
  logic               fin;
  logic               fin_err;

  for (genvar k = 0; k < N_REQ; k++) begin : g_slice
    assign x_arr[k]             = bus.x_bi[16*k +: 16];
    assign bus.y_bo[8*k +: 8]   = y_q[k];
  end

  assign root_idle = (bus.root_busy_bi == 2'd0);
  assign wdog_hit  = (wdog_q == 8'(TIMEOUT - 1));
  assign ptr_inc   = (gnt_q == GW'(N_REQ - 1)) ? '0 : gnt_q + GW'(1);

  // First requester at or after ptr, wrapping past N_REQ-1 back to 0.
  always_comb begin : arb
    logic [GW-1:0] idx;
    int            sum;
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    sum      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = GW'(sum);
      if (!pick_vld && bus.req_i[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wdog_d  = wdog_q;
    y_d     = y_q;
    start_d = start_q;
    rx_d    = rx_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    fin     = 1'b0;
    fin_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (root_idle && pick_vld) begin
          gnt_d       = pick;
          rx_d        = x_arr[pick];
          start_d     = 1'b1;
          ack_d[pick] = 1'b1;
          wdog_d      = '0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (wdog_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
          if (!root_idle) begin
            start_d = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // A genuine completion on the watchdog edge still delivers its result.
        if (root_idle) begin
          fin = 1'b1;
        end else if (wdog_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      y_d[gnt_q]    = fin_err ? 8'd0 : bus.root_y_bi;
      done_d[gnt_q] = 1'b1;
      err_d[gnt_q]  = fin_err;
      start_d       = 1'b0;
      ptr_d         = ptr_inc;
      state_d       = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wdog_q  <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      rx_q    <= '0;
      for (int k = 0; k < N_REQ; k++) y_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wdog_q  <= wdog_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      rx_q    <= rx_d;
      y_q     <= y_d;
    end
  end

  assign bus.ack_o        = ack_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.root_start_o = start_q;
  assign bus.root_x_bo    = rx_q;
endmodule

// File: tb/tb_root_arbiter.sv
// Bench for root_arbiter: behavioural sqrt unit, directed table, corner sequences and a
// randomized phase checked against a round-robin scoreboard.
module tb_root_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  typedef struct {
    int          k;
    logic [15:0] x;
    int          lat;
    logic [7:0]  y;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  root_arbiter_if #(.N_REQ(N)) bus ();
  root_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  logic [N-1:0]   req  = '0;
  logic [N-1:0]   hold = '0;
  logic [16*N-1:0] xb  = '0;
  assign bus.req_i = req;
  assign bus.x_bi  = xb;

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Root unit: mode 0 normal (busy for lat+1 cycles, result valid one cycle), 1 never starts, 2 stuck busy.
  logic [1:0]  rbusy;
  logic [7:0]  ry;
  logic [15:0] rx;
  int          rcnt;
  int          lat   = 2;
  int          rmode = 0;
  assign bus.root_busy_bi = rbusy;
  assign bus.root_y_bi    = ry;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbusy <= 2'd0; ry <= 8'd0; rx <= 16'd0; rcnt <= 0;
    end else begin
      ry <= 8'd0;
      case (rmode)
        1: rbusy <= 2'd0;
        2: begin rbusy <= 2'd3; rcnt <= 0; end
        default: begin
          if (rbusy == 2'd0) begin
            if (bus.root_start_o) begin
              rbusy <= 2'(1 + $urandom_range(0, 2));
              rcnt  <= lat;
              rx    <= bus.root_x_bo;
            end
          end else if (rcnt == 0) begin
            rbusy <= 2'd0;
            ry    <= 8'(isqrt(int'(rx)));
          end else begin
            rcnt <= rcnt - 1;
          end
        end
      endcase
    end
  end

  int vec = 0, miscmp = 0, cyc = 0, start_hi = 0;
  int ack_log[$], ack_t[$], done_log[$], done_t[$];
  int dy_log[$], de_log[$], db_log[$];

  bit              rand_on = 1'b0;
  bit              m_free  = 1'b1;
  int              m_ptr   = 0;
  int              m_out   = -1;
  logic [15:0]     m_x     = '0;
  logic [N-1:0]    req_prev = '0;
  logic [16*N-1:0] x_prev   = '0;
  logic [1:0]      busy_prev = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int k);
    logic [N-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  function automatic logic [7:0] yslice(input int k);
    return 8'(bus.y_bo >> (8 * k));
  endfunction

  function automatic int qv(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic setx(input int k, input logic [15:0] v);
    logic [16*N-1:0] m;
    logic [16*N-1:0] d;
    m  = {{(16*N-16){1'b0}}, 16'hFFFF} << (16 * k);
    d  = {{(16*N-16){1'b0}}, v} << (16 * k);
    xb = (xb & ~m) | d;
  endtask

  task automatic raise(input int k);
    req = req | (N'(1) << k);
  endtask

  task automatic model_check();
    logic [N-1:0] exp_ack;
    int g;
    exp_ack = '0;
    g = -1;
    if (m_free && req_prev != '0 && busy_prev == 2'd0) begin
      for (int i = 0; i < N; i++)
        if (g < 0 && bit_of(req_prev, (m_ptr + i) % N)) g = (m_ptr + i) % N;
      exp_ack = N'(1) << g;
    end
    check("rnd_ack", bus.ack_o, exp_ack);
    if (g >= 0) begin
      m_free = 1'b0;
      m_out  = g;
      m_x    = 16'(x_prev >> (16 * g));
    end
    if (bus.done_o != '0) begin
      if (m_out < 0) begin
        check("rnd_spurious_done", bus.done_o, 0);
      end else begin
        check("rnd_done_who", bus.done_o, N'(1) << m_out);
        check("rnd_y", yslice(m_out), isqrt(int'(m_x)));
        check("rnd_err", bus.err_o, 0);
        m_ptr  = (m_out + 1) % N;
        m_out  = -1;
        m_free = 1'b1;
      end
    end
  endtask

  task automatic tick();
    req_prev  = req;
    x_prev    = xb;
    busy_prev = rbusy;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.root_start_o) start_hi++;
    if (rand_on) model_check();
    for (int k = 0; k < N; k++) begin
      if (bit_of(bus.ack_o, k)) begin
        ack_log.push_back(k);
        ack_t.push_back(cyc);
        if (!bit_of(hold, k)) req = req & ~(N'(1) << k);
      end
      if (bit_of(bus.done_o, k)) begin
        done_log.push_back(k);
        done_t.push_back(cyc);
        dy_log.push_back(int'(yslice(k)));
        de_log.push_back(int'(bit_of(bus.err_o, k)));
        db_log.push_back(int'(bus.busy_o));
      end
    end
  endtask

  task automatic clear_logs();
    ack_log.delete(); ack_t.delete(); done_log.delete(); done_t.delete();
    dy_log.delete(); de_log.delete(); db_log.delete();
    start_hi = 0;
  endtask

  task automatic wait_done(input int n, input int budget, input string nm);
    int t = 0;
    while (done_log.size() < n && t < budget) begin
      tick();
      t++;
    end
    check(nm, done_log.size(), n);
  endtask

  task automatic do_reset();
    req = '0; hold = '0; rmode = 0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ack"},   bus.ack_o, 0);
    check({pfx, "_done"},  bus.done_o, 0);
    check({pfx, "_y"},     bus.y_bo, 0);
    check({pfx, "_err"},   bus.err_o, 0);
    check({pfx, "_busy"},  bus.busy_o, 0);
    check({pfx, "_start"}, bus.root_start_o, 0);
    check({pfx, "_rootx"}, bus.root_x_bo, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t tbl[10];
    int   e4[4];
    int   pat[3];
    int   t;
    tbl[0] = '{0, 16'd144,   2, 8'd12};
    tbl[1] = '{1, 16'd50,    0, 8'd7};
    tbl[2] = '{2, 16'd225,   4, 8'd15};
    tbl[3] = '{3, 16'd81,    1, 8'd9};
    tbl[4] = '{2, 16'd0,     3, 8'd0};
    tbl[5] = '{1, 16'd65535, 2, 8'd255};
    tbl[6] = '{0, 16'd1,     0, 8'd1};
    tbl[7] = '{3, 16'd255,   4, 8'd15};
    tbl[8] = '{3, 16'd256,   2, 8'd16};
    tbl[9] = '{0, 16'd10000, 1, 8'd100};
    e4  = '{0, 7, 15, 9};
    pat = '{0, 1, 3};

    #1 rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      clear_logs();
      lat = tbl[i].lat;
      setx(tbl[i].k, tbl[i].x);
      raise(tbl[i].k);
      wait_done(1, 40, $sformatf("tbl%0d_done_cnt", i));
      check($sformatf("tbl%0d_ack", i), qv(ack_log, 0), tbl[i].k);
      check($sformatf("tbl%0d_start_cycles", i), start_hi, 2);
      check($sformatf("tbl%0d_done_who", i), qv(done_log, 0), tbl[i].k);
      check($sformatf("tbl%0d_y", i), qv(dy_log, 0), tbl[i].y);
      check($sformatf("tbl%0d_err", i), qv(de_log, 0), 0);
      check($sformatf("tbl%0d_busy_at_done", i), qv(db_log, 0), 0);
      check($sformatf("tbl%0d_latency", i), qv(done_t, 0) - qv(ack_t, 0), tbl[i].lat + 3);
      tick();
    end

    do_reset();
    clear_logs();
    lat = 1;
    setx(0, 16'd0); setx(1, 16'd50); setx(2, 16'd225); setx(3, 16'd81);
    req = '1;
    wait_done(4, 80, "all4_done_cnt");
    check("all4_ack_cnt", ack_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("all4_ack%0d", i), qv(ack_log, i), i);
      check($sformatf("all4_done%0d", i), qv(done_log, i), i);
      check($sformatf("all4_y%0d", i), qv(dy_log, i), e4[i]);
      check($sformatf("all4_err%0d", i), qv(de_log, i), 0);
    end

    do_reset();
    clear_logs();
    lat = 0;
    setx(0, 16'd100); setx(1, 16'd100); setx(3, 16'd100);
    hold = 4'b1011;
    req  = 4'b1011;
    t = 0;
    while (ack_log.size() < 6 && t < 150) begin tick(); t++; end
    check("fair_ack_cnt", ack_log.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("fair_ack%0d", i), qv(ack_log, i), pat[i % 3]);
    hold = '0;
    req  = '0;
    repeat (12) tick();

    clear_logs();
    check("to_pre_y0", yslice(0), 10);
    rmode = 1;
    setx(0, 16'd400);
    raise(0);
    wait_done(1, 40, "to_done_cnt");
    check("to_done_who", qv(done_log, 0), 0);
    check("to_err", qv(de_log, 0), 1);
    check("to_y_cleared", qv(dy_log, 0), 0);
    check("to_cycles", qv(done_t, 0) - qv(ack_t, 0), TO);
    rmode = 2;
    tick();
    setx(1, 16'd49);
    raise(1);
    repeat (12) tick();
    check("to_no_grant_while_busy", ack_log.size(), 1);
    rmode = 0;
    wait_done(2, 40, "to_resume_done_cnt");
    check("to_resume_ack", qv(ack_log, 1), 1);
    check("to_resume_y", qv(dy_log, 1), 7);
    check("to_resume_err", qv(de_log, 1), 0);

    clear_logs();
    lat = 4;
    setx(1, 16'd900);
    raise(1);
    t = 0;
    while (ack_log.size() < 1 && t < 20) begin tick(); t++; end
    check("rst_pre_ack", ack_log.size(), 1);
    setx(2, 16'd1600); setx(3, 16'd36);
    req = req | 4'b1100;
    repeat (3) tick();
    check("rst_pre_busy", bus.busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    clear_logs();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    wait_done(2, 60, "rst_after_done_cnt");
    check("rst_after_ack0", qv(ack_log, 0), 2);
    check("rst_after_ack1", qv(ack_log, 1), 3);
    check("rst_after_done0", qv(done_log, 0), 2);
    check("rst_after_done1", qv(done_log, 1), 3);
    check("rst_after_y2", qv(dy_log, 0), 40);
    check("rst_after_y3", qv(dy_log, 1), 6);

    clear_logs();
    lat = 1;
    setx(0, 16'd64);
    raise(0);
    wait_done(1, 40, "samecyc_first_done");
    setx(1, 16'd121);
    raise(1);
    tick();
    check("samecyc_who", qv(ack_log, 1), 1);
    check("samecyc_gap", qv(ack_t, 1) - qv(done_t, 0), 1);
    wait_done(2, 40, "samecyc_second_done");
    check("samecyc_y", qv(dy_log, 1), 11);

    do_reset();
    clear_logs();
    m_free  = 1'b1;
    m_ptr   = 0;
    m_out   = -1;
    rand_on = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      lat = $urandom_range(0, 4);
      for (int k = 0; k < N; k++) begin
        if (!bit_of(req, k) && $urandom_range(0, 3) == 0) begin
          setx(k, 16'($urandom));
          raise(k);
        end
      end
      tick();
    end
    t = 0;
    while ((req != '0 || !m_free) && t < 200) begin tick(); t++; end
    check("rnd_drain_req", req, 0);
    check("rnd_drain_free", m_free, 1);
    rand_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
